// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: maps centre-origin pixels to screen addresses, clips off-screen pixels,
// queues survivors and writes them to a framebuffer; also runs a full-screen clear. Option: PIXEL_COUNTERS_EN.
module pixel_fb_writer #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 17,
   parameter int COLOR_W    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pix_valid,
   input  logic signed [8:0]   pix_x,
   input  logic signed [7:0]   pix_y,
   input  logic [COLOR_W-1:0]  pix_color,
   output logic                pix_ready,
   input  logic                clr_req,
   input  logic [COLOR_W-1:0]  clr_color,
   output logic                fb_we,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic [COLOR_W-1:0]  fb_wdata,
   input  logic                fb_ready,
   output logic                busy,
   output logic [15:0]         clip_cnt,
   output logic [15:0]         wr_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic signed [10:0] H_HALF = 11'(H_RES / 2);
   localparam logic signed [10:0] V_HALF = 11'(V_RES / 2);
   localparam logic signed [10:0] H_LIM  = 11'(H_RES);
   localparam logic signed [10:0] V_LIM  = 11'(V_RES);
   localparam logic [ADDR_W-1:0]  H_RES_A   = ADDR_W'(H_RES);
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [CW:0]        DEPTH_V   = FIFO_DEPTH[CW:0];

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] color;
   } entry_t;

   state_t             state;
   logic               s1_valid;
   logic               s1_clip;
   entry_t             s1_entry;
   entry_t             mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      fifo_count;
   logic               clr_pend;
   logic [COLOR_W-1:0] clr_color_q;

   logic signed [10:0] sx, sy;
   logic               clip_c;
   logic [ADDR_W-1:0]  addr_c;
   logic [CW:0]        occ;
   logic               accept, push, pop, enter_clear;
   entry_t             head, nxt;

   // 11-bit signed math keeps the offset sums of a 9-bit/8-bit input from wrapping.
   always_comb begin
      sx     = 11'(pix_x) + H_HALF;
      sy     = V_HALF - 11'(pix_y);
      clip_c = sx[10] || sy[10] || (sx >= H_LIM) || (sy >= V_LIM);
      addr_c = ADDR_W'(sy[9:0]) * H_RES_A + ADDR_W'(sx[9:0]);
   end

   // Slot accounting uses registered state only, so a pop never frees room in the same cycle.
   assign occ         = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
   assign pix_ready   = (state != S_CLEAR) && !clr_pend && (occ < DEPTH_V);
   assign accept      = pix_valid && pix_ready;
   assign push        = s1_valid && !s1_clip;
   assign pop         = fb_we && fb_ready && (state != S_CLEAR);
   assign enter_clear = (state != S_CLEAR) && clr_pend && !fb_we;
   assign head        = mem[rd_ptr];
   assign nxt         = mem[rd_ptr + PW'(1)];
   assign busy        = s1_valid || (fifo_count != '0) || fb_we || clr_pend || (state == S_CLEAR);

   // NOTE: queue storage is not reset; fifo_count guards every read, so stale words are never used.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s1_entry;
   end

   // The presented write stays at the queue head until its transfer edge, so fb_we is never retracted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         s1_valid    <= 1'b0;
         s1_clip     <= 1'b0;
         s1_entry    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_wdata    <= '0;
         clr_pend    <= 1'b0;
         clr_color_q <= '0;
      end else begin
         if (clr_req && (state != S_CLEAR) && !clr_pend) begin
            clr_pend    <= 1'b1;
            clr_color_q <= clr_color;
         end
         if (state == S_CLEAR) begin
            if (fb_ready) begin
               if (fb_addr == LAST_ADDR) begin
                  fb_we    <= 1'b0;
                  clr_pend <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  fb_addr <= fb_addr + ADDR_W'(1);
               end
            end
         end else if (enter_clear) begin
            state      <= S_CLEAR;
            s1_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fb_we      <= 1'b1;
            fb_addr    <= '0;
            fb_wdata   <= clr_color_q;
         end else begin
            s1_valid <= accept;
            if (accept) begin
               s1_entry <= '{addr: addr_c, color: pix_color};
               s1_clip  <= clip_c;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   fifo_count <= fifo_count + CW'(1);
               2'b01:   fifo_count <= fifo_count - CW'(1);
               default: fifo_count <= fifo_count;
            endcase
            if (pop) begin
               if ((fifo_count > CW'(1)) && !clr_pend) begin
                  fb_addr  <= nxt.addr;
                  fb_wdata <= nxt.color;
               end else begin
                  fb_we <= 1'b0;
               end
            end else if (!fb_we && (fifo_count != '0) && !clr_pend) begin
               fb_we    <= 1'b1;
               fb_addr  <= head.addr;
               fb_wdata <= head.color;
            end
            if ((state == S_IDLE) && (fifo_count != '0)) begin
               state <= S_DRAIN;
            end else if ((state == S_DRAIN) && (fifo_count == '0) && !fb_we) begin
               state <= S_IDLE;
            end
         end
      end
   end

`ifdef PIXEL_COUNTERS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clip_cnt <= '0;
         wr_cnt   <= '0;
      end else if (enter_clear) begin
         clip_cnt <= '0;
         wr_cnt   <= '0;
      end else begin
         if (s1_valid && s1_clip && (clip_cnt != 16'hFFFF)) clip_cnt <= clip_cnt + 16'd1;
         if (pop && (wr_cnt != 16'hFFFF))                   wr_cnt   <= wr_cnt + 16'd1;
      end
   end
`else
   assign clip_cnt = '0;
   assign wr_cnt   = '0;
`endif

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer: table vectors plus multi-cycle sequences; a write-order scoreboard
// checks every framebuffer transfer against expectations queued when pixels are accepted.
module tb_pixel_fb_writer;

   localparam int H_RES   = 320;
   localparam int V_RES   = 240;
   localparam int NPIX    = H_RES * V_RES;

   typedef struct {
      int x;
      int y;
      int color;
      bit kept;
      int addr;
   } vec_t;

   typedef struct {
      int addr;
      int color;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              pix_valid;
   logic signed [8:0] pix_x;
   logic signed [7:0] pix_y;
   logic [3:0]        pix_color;
   logic              pix_ready;
   logic              clr_req;
   logic [3:0]        clr_color;
   logic              fb_we;
   logic [16:0]       fb_addr;
   logic [3:0]        fb_wdata;
   logic              fb_ready;
   logic              busy;
   logic [15:0]       clip_cnt;
   logic [15:0]       wr_cnt;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   wr_exp = 0;
   int   clip_exp = 0;
   int   pix_wr_seen = 0;
   bit   clr_active = 0;
   int   clr_col = 0;
   int   clr_next = 0;
   int   clr_seen = 0;
   int   clr_errs = 0;
   bit   rand_ready = 0;

   pixel_fb_writer dut (
      .clk       (clk),
      .reset     (reset),
      .pix_valid (pix_valid),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_color (pix_color),
      .pix_ready (pix_ready),
      .clr_req   (clr_req),
      .clr_color (clr_color),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .fb_ready  (fb_ready),
      .busy      (busy),
      .clip_cnt  (clip_cnt),
      .wr_cnt    (wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic bit model_kept(input int x, input int y);
      int sx, sy;
      sx = x + H_RES / 2;
      sy = V_RES / 2 - y;
      return (sx >= 0) && (sx < H_RES) && (sy >= 0) && (sy < V_RES);
   endfunction

   function automatic int model_addr(input int x, input int y);
      return (V_RES / 2 - y) * H_RES + (x + H_RES / 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_pix(input int x, input int y, input int c, input bit kept, input int addr);
      int n;
      exp_t e;
      pix_x     = 9'(x);
      pix_y     = 8'(y);
      pix_color = 4'(c);
      pix_valid = 1'b1;
      n = 0;
      while (!pix_ready && n < 500) begin
         tick();
         n++;
      end
      if (!pix_ready) begin
         check("send_pix_ready", 32'(pix_ready), 32'd1);
      end else begin
         if (kept) begin
            e.addr  = addr;
            e.color = c;
            exp_q.push_back(e);
         end else begin
            clip_exp++;
         end
         tick();
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_counters(input string tag);
`ifdef PIXEL_COUNTERS_EN
      check({tag, "_clip_cnt"}, 32'(clip_cnt), 32'(clip_exp));
      check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(wr_exp));
`else
      check({tag, "_clip_cnt"}, 32'(clip_cnt), 32'd0);
      check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
`endif
   endtask

   // Scoreboard: pixel writes pop the expectation queue; clear writes follow a running address.
   always @(negedge clk) begin
      if (reset && fb_we && fb_ready) begin
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
            check("wr_data", 32'(fb_wdata), 32'(mon_e.color));
            wr_exp++;
            pix_wr_seen++;
         end else if (clr_active) begin
            if (32'(fb_addr) != 32'(clr_next) || 32'(fb_wdata) != 32'(clr_col)) clr_errs++;
            clr_next++;
            clr_seen++;
         end else begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr=%0d data=%0d, no write was expected", fb_addr, fb_wdata);
         end
      end
   end

   initial begin
      vec_t vecs[11];
      int   cx[64];
      int   cy[64];
      int   idx, acc, seen0;
      int   px, py, d, np;

      vecs[0]  = '{x: -160, y:  120, color: 1, kept: 1, addr: 0};
      vecs[1]  = '{x:  159, y: -119, color: 2, kept: 1, addr: 76799};
      vecs[2]  = '{x:  160, y:    0, color: 3, kept: 0, addr: 0};
      vecs[3]  = '{x:    0, y: -120, color: 4, kept: 0, addr: 0};
      vecs[4]  = '{x: -161, y:    0, color: 5, kept: 0, addr: 0};
      vecs[5]  = '{x:    0, y:  121, color: 6, kept: 0, addr: 0};
      vecs[6]  = '{x: -256, y: -128, color: 7, kept: 0, addr: 0};
      vecs[7]  = '{x:  255, y:  127, color: 8, kept: 0, addr: 0};
      vecs[8]  = '{x:   10, y:   20, color: 9, kept: 1, addr: 32170};
      vecs[9]  = '{x:   -1, y:    1, color: 10, kept: 1, addr: 38239};
      vecs[10] = '{x:  100, y:  -50, color: 15, kept: 1, addr: 54660};

      // Midpoint circle, radius 125: eight octant points per step; the top/bottom run off-screen.
      px = 0; py = 125; d = 1 - 125; np = 0;
      for (int s = 0; s < 8; s++) begin
         cx[np] =  px; cy[np] =  py; np++;
         cx[np] =  py; cy[np] =  px; np++;
         cx[np] = -px; cy[np] =  py; np++;
         cx[np] = -py; cy[np] =  px; np++;
         cx[np] =  px; cy[np] = -py; np++;
         cx[np] =  py; cy[np] = -px; np++;
         cx[np] = -px; cy[np] = -py; np++;
         cx[np] = -py; cy[np] = -px; np++;
         px++;
         if (d < 0) d = d + 2 * px + 1;
         else begin
            py--;
            d = d + 2 * (px - py) + 1;
         end
      end

      reset = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
      clr_req = 1'b0; clr_color = '0; fb_ready = 1'b1;
      repeat (3) tick();
      check("rst_pix_ready", 32'(pix_ready), 32'd1);
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_fb_addr", 32'(fb_addr), 32'd0);
      check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_counters("rst");
      reset = 1'b1;
      tick();

      // Latency: acceptance edge, then two edges until fb_we, held for one cycle with fb_ready=1.
      send_pix(0, 0, 5, 1'b1, 38560);
      check("lat_we_t0", 32'(fb_we), 32'd0);
      tick();
      check("lat_we_t1", 32'(fb_we), 32'd0);
      tick();
      check("lat_we_t2", 32'(fb_we), 32'd1);
      check("lat_addr", 32'(fb_addr), 32'd38560);
      check("lat_data", 32'(fb_wdata), 32'd5);
      tick();
      check("lat_we_t3", 32'(fb_we), 32'd0);
      wait_idle(50, "lat");

      for (int i = 0; i < 11; i++) begin
         send_pix(vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].kept, vecs[i].addr);
      end
      wait_idle(100, "table");
      check_counters("table");

      // Back-pressure: fb_ready low, ten pixels offered; eight fit, then in-order back-to-back drain.
      fb_ready = 1'b0; idx = 0; acc = 0; seen0 = 0;
      pix_x = 9'(idx * 3 - 10); pix_y = 8'(idx); pix_color = 4'(idx + 1); pix_valid = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc == 10 || cyc == 19) begin
            check("stall_we", 32'(fb_we), 32'd1);
            check("stall_addr", 32'(fb_addr), 32'(model_addr(-10, 0)));
            check("stall_data", 32'(fb_wdata), 32'd1);
         end
         if (cyc == 19) begin
            check("full_accepted", 32'(acc), 32'd8);
            check("full_pix_ready", 32'(pix_ready), 32'd0);
         end
         if (cyc == 20) begin
            fb_ready = 1'b1;
            seen0 = pix_wr_seen;
         end
         if (cyc == 28) check("b2b_writes", 32'(pix_wr_seen - seen0), 32'd8);
         if (pix_valid && pix_ready) begin
            exp_q.push_back('{addr: model_addr(idx * 3 - 10, idx), color: idx + 1});
            acc++;
            idx++;
         end
         tick();
         if (idx < 10) begin
            pix_x = 9'(idx * 3 - 10); pix_y = 8'(idx); pix_color = 4'(idx + 1);
         end else begin
            pix_valid = 1'b0;
         end
      end
      pix_valid = 1'b0;
      check("bp_accepted_all", 32'(acc), 32'd10);
      wait_idle(100, "bp");

      // Clear with four pixels queued: only the presented write completes, then the full fill.
      fb_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_pix(-50 + i, 30, 12, 1'b1, model_addr(-50 + i, 30));
      repeat (3) tick();
      check("clr_pre_we", 32'(fb_we), 32'd1);
      clr_req = 1'b1; clr_color = 4'd3;
      tick();
      clr_req = 1'b0; clr_color = 4'd0;
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      clr_active = 1'b1; clr_col = 3; clr_next = 0; clr_seen = 0; clr_errs = 0;
      tick();
      check("clr_pend_ready", 32'(pix_ready), 32'd0);
      check("clr_pend_busy", 32'(busy), 32'd1);
      fb_ready = 1'b1;
      wait_idle(80000, "clear");
      check("clear_writes", 32'(clr_seen), 32'(NPIX));
      check("clear_errors", 32'(clr_errs), 32'd0);
      check("clear_we_end", 32'(fb_we), 32'd0);
      clr_active = 1'b0;
      wr_exp = 0; clip_exp = 0;
      check_counters("clear");

      // Reset in the middle of a second clear aborts at once.
      send_pix(0, 125, 2, 1'b0, 0);
      clr_req = 1'b1; clr_color = 4'd9;
      tick();
      clr_req = 1'b0;
      clr_active = 1'b1; clr_col = 9; clr_next = 0; clr_seen = 0; clr_errs = 0;
      repeat (100) tick();
      check("midclr_we", 32'(fb_we), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("rstclr_fb_we", 32'(fb_we), 32'd0);
      check("rstclr_pix_ready", 32'(pix_ready), 32'd1);
      check("rstclr_busy", 32'(busy), 32'd0);
      wr_exp = 0; clip_exp = 0;
      check_counters("rstclr");
      check("midclr_errors", 32'(clr_errs), 32'd0);
      clr_active = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_we", 32'(fb_we), 32'd0);

      // Circle stream with a randomly stalling framebuffer.
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         send_pix(cx[i], cy[i], (i % 15) + 1, model_kept(cx[i], cy[i]), model_addr(cx[i], cy[i]));
      end
      rand_ready = 1'b0;
      fb_ready = 1'b1;
      wait_idle(500, "circle");
      check_counters("circle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
